// File: rtl/tt_extractor_pkg.sv
// Shared constants, FSM state type and a hex formatting helper for the
// truth-table extractor.
package tt_pkg;

   localparam int unsigned N_IN_DEF = 7;
   localparam int unsigned TT_W_DEF = 128;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

   function automatic string tt_to_hex_str(input logic [TT_W_DEF-1:0] tt);
      return $sformatf("%h", tt);
   endfunction

endpackage

// File: rtl/tt_extractor_lat_pipe.sv
// LAT-deep {vld, idx} delay line that tracks samples through the
// function-under-test; a plain wire-through when LAT is zero.
module tt_lat_pipe #(
   parameter int unsigned LAT = 0,
   parameter int unsigned W   = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         vld_in,
   input  logic [W-1:0] idx_in,
   output logic         vld_out,
   output logic [W-1:0] idx_out
);

   if (LAT == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign vld_out        = vld_in;
      assign idx_out        = idx_in;
   end else begin : g_pipe
      logic [LAT-1:0] vld_q;
      logic [LAT-1:0] vld_d;
      logic [W-1:0]   idx_q [LAT];
      logic [W-1:0]   idx_d [LAT];

      always_comb begin
         vld_d[0] = vld_in;
         idx_d[0] = idx_in;
         for (int unsigned i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
               idx_q[i] <= '0;
            end
         end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
         end
      end

      assign vld_out = vld_q[LAT-1];
      assign idx_out = idx_q[LAT-1];
   end

endmodule

// File: rtl/tt_extractor.sv
// Sweeps every input vector into a function-under-test and reassembles its
// outputs into a truth-table word, its on-set size and an expected-table match.
module tt_extractor
   import tt_pkg::*;
#(
   parameter  int unsigned N_IN = N_IN_DEF,
   parameter  int unsigned LAT  = 0,
   localparam int unsigned TT_W = 2 ** N_IN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [N_IN-1:0] probe,
   output logic            probe_vld,
   input  logic            f_in,
   input  logic [TT_W-1:0] exp_tt,
   output logic [TT_W-1:0] tt,
   output logic [N_IN:0]   ones,
   output logic            match
);

   localparam int unsigned DW = $clog2(LAT + 2);

   state_e          state_q, state_d;
   logic [N_IN:0]   idx_q, idx_d;
   logic [N_IN-1:0] probe_q, probe_d;
   logic            probe_vld_q, probe_vld_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [TT_W-1:0] tt_q, tt_d;
   logic [TT_W-1:0] exp_q, exp_d;
   logic [N_IN:0]   ones_q, ones_d;
   logic            match_q, match_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            sweep_end;
   logic            dly_vld;
   logic [N_IN-1:0] dly_idx;

   tt_lat_pipe #(
      .LAT (LAT),
      .W   (N_IN)
   ) u_lat_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld_in  (probe_vld_q),
      .idx_in  (probe_q),
      .vld_out (dly_vld),
      .idx_out (dly_idx)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      probe_d     = probe_q;
      probe_vld_d = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      tt_d        = tt_q;
      exp_d       = exp_q;
      ones_d      = ones_q;
      match_d     = match_q;
      drain_d     = drain_q;
      sweep_end   = 1'b0;

      if (dly_vld) begin
         tt_d[dly_idx] = f_in;
         ones_d        = ones_q + (N_IN+1)'(f_in);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SWEEP;
               tt_d        = '0;
               ones_d      = '0;
               match_d     = 1'b0;
               exp_d       = exp_tt;
               probe_d     = '0;
               probe_vld_d = 1'b1;
               idx_d       = (N_IN+1)'(1);
               busy_d      = 1'b1;
            end
         end
         SWEEP: begin
            // idx runs one ahead of probe, so TT_W means the last vector is on the bus now
            if (idx_q == (N_IN+1)'(TT_W)) begin
               if (LAT == 0) begin
                  sweep_end = 1'b1;
               end else begin
                  state_d = DRAIN;
                  drain_d = DW'(LAT - 1);
               end
            end else begin
               probe_d     = idx_q[N_IN-1:0];
               probe_vld_d = 1'b1;
               idx_d       = idx_q + (N_IN+1)'(1);
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               sweep_end = 1'b1;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (sweep_end) begin
         state_d = DONE;
         done_d  = 1'b1;
         busy_d  = 1'b0;
         match_d = (tt_d == exp_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         probe_q     <= '0;
         probe_vld_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tt_q        <= '0;
         exp_q       <= '0;
         ones_q      <= '0;
         match_q     <= 1'b0;
         drain_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         probe_q     <= probe_d;
         probe_vld_q <= probe_vld_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tt_q        <= tt_d;
         exp_q       <= exp_d;
         ones_q      <= ones_d;
         match_q     <= match_d;
         drain_q     <= drain_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign probe     = probe_q;
   assign probe_vld = probe_vld_q;
   assign tt        = tt_q;
   assign ones      = ones_q;
   assign match     = match_q;

endmodule

// File: tb/tb_tt_extractor.sv
// Bench for tt_extractor: three instances (LAT 0, 2, 3) driven by a model FUT,
// results checked against a table of hand-derived truth tables via scoreboards.
module tb_tt_extractor;
   import tt_pkg::*;

   typedef struct {
      logic [127:0] tt;
      logic [7:0]   ones;
      logic         match;
      int           done_cyc;
   } exp_t;

   typedef struct {
      int           dut;   // also the instance's LAT
      int           sel;
      int           fdly;
      logic [127:0] exp_in;
      logic [127:0] tt;
      logic [7:0]   ones;
      logic         match;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic fut(input int sel, input logic [6:0] p);
      case (sel)
         0:       return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
         1:       return &p;
         2:       return 1'b0;
         3:       return p[6];
         default: return p[0] ^ p[3];
      endcase
   endfunction

   logic         start0 = 1'b0, start2 = 1'b0, start3 = 1'b0;
   logic [127:0] exp0 = '0, exp2 = '0, exp3 = '0;
   int           sel0 = 0, sel2 = 0, sel3 = 0, fdly3 = 3;
   logic         busy0, busy2, busy3, done0, done2, done3;
   logic         pv0, pv2, pv3, match0, match2, match3;
   logic [6:0]   probe0, probe2, probe3;
   logic [127:0] tt0, tt2, tt3;
   logic [7:0]   ones0, ones2, ones3;
   logic         f_in0, f_in2, f_in3;
   logic [1:0]   s2 = '0;
   logic [2:0]   s3 = '0;

   assign f_in0 = fut(sel0, probe0);
   always @(posedge clk) s2 <= {s2[0], fut(sel2, probe2)};
   always @(posedge clk) s3 <= {s3[1:0], fut(sel3, probe3)};
   assign f_in2 = s2[1];
   assign f_in3 = (fdly3 == 3) ? s3[2] : s3[1];

   tt_extractor #(.N_IN(7), .LAT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
      .probe(probe0), .probe_vld(pv0), .f_in(f_in0), .exp_tt(exp0),
      .tt(tt0), .ones(ones0), .match(match0));
   tt_extractor #(.N_IN(7), .LAT(2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
      .probe(probe2), .probe_vld(pv2), .f_in(f_in2), .exp_tt(exp2),
      .tt(tt2), .ones(ones2), .match(match2));
   tt_extractor #(.N_IN(7), .LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
      .probe(probe3), .probe_vld(pv3), .f_in(f_in3), .exp_tt(exp3),
      .tt(tt3), .ones(ones3), .match(match3));

   exp_t sb0[$], sb2[$], sb3[$];

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%s want=%s", nm, tt_to_hex_str(got), tt_to_hex_str(want));
      end
   endtask

   task automatic check_res(input string nm, input exp_t e, input logic [127:0] t,
                            input logic [7:0] o, input logic m, input logic b);
      chk({nm, "_tt"}, t, e.tt);
      chk({nm, "_ones"}, 128'(o), 128'(e.ones));
      chk({nm, "_match"}, 128'(m), 128'(e.match));
      chk({nm, "_busy_at_done"}, 128'(b), '0);
      chk({nm, "_done_cycle"}, 128'(cyc), 128'(e.done_cyc));
   endtask

   task automatic unexpected_done(input string nm);
      checks++;
      failures++;
      $display("FAIL %s_unexpected_done got=done want=no_done cyc=%0d", nm, cyc);
   endtask

   always @(negedge clk) if (done0) begin
      if (sb0.size() == 0) unexpected_done("u0"); else check_res("u0", sb0.pop_front(), tt0, ones0, match0, busy0);
   end
   always @(negedge clk) if (done2) begin
      if (sb2.size() == 0) unexpected_done("u2"); else check_res("u2", sb2.pop_front(), tt2, ones2, match2, busy2);
   end
   always @(negedge clk) if (done3) begin
      if (sb3.size() == 0) unexpected_done("u3"); else check_res("u3", sb3.pop_front(), tt3, ones3, match3, busy3);
   end

   // Probe order and FUT-output sanity on the LAT=0 instance
   int pexp0 = 0;
   always @(negedge clk) begin
      if (pv0) begin
         checks++;
         if (probe0 !== 7'(pexp0) || busy0 !== 1'b1 || $isunknown(f_in0)) begin
            failures++;
            $display("FAIL u0_probe got=%0h busy=%b f_in=%b want=%0h busy=1 f_in=known", probe0, busy0, f_in0, 7'(pexp0));
         end
         pexp0++;
      end
      if (done0) begin
         checks++;
         if (pexp0 != 128) begin
            failures++;
            $display("FAIL u0_probe_count got=%0d want=128", pexp0);
         end
      end
      if (!busy0) pexp0 = 0;
   end

   function automatic int qsize(input int k);
      case (k)
         0:       return sb0.size();
         2:       return sb2.size();
         default: return sb3.size();
      endcase
   endfunction

   task automatic wait_idle(input int k, input int bound);
      int n = 0;
      while (qsize(k) != 0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (qsize(k) != 0) begin
         checks++;
         failures++;
         $display("FAIL u%0d_timeout got=pending:%0d want=pending:0", k, qsize(k));
         sb0.delete(); sb2.delete(); sb3.delete();
      end
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      e.tt = v.tt; e.ones = v.ones; e.match = v.match;
      e.done_cyc = cyc + 129 + v.dut;
      fdly3 = v.fdly;
      case (v.dut)
         0:       begin sel0 = v.sel; exp0 = v.exp_in; sb0.push_back(e); start0 = 1'b1; end
         2:       begin sel2 = v.sel; exp2 = v.exp_in; sb2.push_back(e); start2 = 1'b1; end
         default: begin sel3 = v.sel; exp3 = v.exp_in; sb3.push_back(e); start3 = 1'b1; end
      endcase
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0; start3 = 1'b0;
      // latched at start, so scrambling it now must not change match
      exp0 = ~v.exp_in; exp2 = ~v.exp_in; exp3 = ~v.exp_in;
      wait_idle(v.dut, 400);
   endtask

   vec_t vecs[7];
   exp_t e;
   int   c;

   initial begin
      vecs[0] = '{0, 0, 3, {16{8'hE8}}, {16{8'hE8}}, 8'd64, 1'b1};
      vecs[1] = '{0, 2, 3, '0, '0, 8'd0, 1'b1};
      vecs[2] = '{0, 3, 3, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 8'd64, 1'b1};
      vecs[3] = '{2, 1, 3, {1'b1, 127'b0}, {1'b1, 127'b0}, 8'd1, 1'b1};
      vecs[4] = '{2, 1, 3, {1'b1, 126'b0, 1'b1}, {1'b1, 127'b0}, 8'd1, 1'b0};
      vecs[5] = '{3, 4, 3, {8{16'h55AA}}, {8{16'h55AA}}, 8'd64, 1'b1};
      // FUT one cycle short of LAT: every bit lands one slot low
      vecs[6] = '{3, 4, 2, {8{16'h55AA}}, ({8{16'h55AA}} >> 1), 8'd64, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst_flags", 128'({busy0, done0, pv0, match0}), '0);
      chk("rst_probe", 128'(probe0), '0);
      chk("rst_tt", tt0, '0);
      chk("rst_ones", 128'(ones0), '0);
      chk("rst_u3_tt", tt3, '0);
      rst_n = 1'b1;
      @(negedge clk);

      run_vec(vecs[0]);
      repeat (4) @(negedge clk);
      chk("hold_tt", tt0, {16{8'hE8}});
      chk("hold_ones_match", 128'({ones0, match0}), 128'({8'd64, 1'b1}));
      chk("hold_probe_idle", 128'({probe0, pv0, busy0, done0}), 128'({7'h7F, 3'b000}));

      for (int i = 1; i < 7; i++) begin
         run_vec(vecs[i]);
         repeat (2) @(negedge clk);
      end

      // start re-pulsed mid-sweep and in the DONE cycle: one result only
      c = cyc;
      sel0 = 0; exp0 = {16{8'hE8}};
      e = '{{16{8'hE8}}, 8'd64, 1'b1, c + 129};
      sb0.push_back(e);
      start0 = 1'b1;
      for (int n = 1; n <= 135; n++) begin
         @(negedge clk);
         start0 = (n == 5 || n == 60 || n == 129);
      end
      start0 = 1'b0;
      repeat (150) @(negedge clk);
      chk("repulse_pending", 128'(sb0.size()), '0);
      chk("repulse_idle", 128'({busy0, pv0}), '0);

      // start held high: back-to-back sweeps every 130 cycles
      c = cyc;
      for (int k = 0; k < 3; k++) begin
         e = '{{16{8'hE8}}, 8'd64, 1'b1, c + 129 + 130 * k};
         sb0.push_back(e);
      end
      start0 = 1'b1;
      repeat (300) @(negedge clk);
      start0 = 1'b0;
      wait_idle(0, 200);
      repeat (20) @(negedge clk);
      chk("b2b_idle", 128'({busy0, pv0}), '0);

      // reset mid-sweep: partial table discarded, no done
      sel0 = 3;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (39) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_flags", 128'({busy0, done0, pv0, match0}), '0);
      chk("abort_probe", 128'(probe0), '0);
      chk("abort_tt", tt0, '0);
      chk("abort_ones", 128'(ones0), '0);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("abort_no_done_busy", 128'(busy0), '0);
      run_vec(vecs[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

endmodule
